// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared definitions for the microcoded CPU control sequencer.
// Holds the FSM state encoding, the opcode map, the fixed instruction length
// and the bundle of control strobes produced by the decoder.
package cpu_ctrl_pkg;

    // Every instruction spends this many enabled cycles from F_ADDR to F_ADDR
    localparam int INSTR_LEN = 7;

    // Opcode map; values 7..14 are unassigned and behave as NOP
    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_OUT = 4'd4;
    localparam logic [3:0] OP_JMP = 4'd5;
    localparam logic [3:0] OP_JZ  = 4'd6;
    localparam logic [3:0] OP_HLT = 4'd15;

    // Sequencer states
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_F_ADDR = 4'd1,
        ST_F_INC  = 4'd2,
        ST_F_IR   = 4'd3,
        ST_DECODE = 4'd4,
        ST_EX1    = 4'd5,
        ST_EX2    = 4'd6,
        ST_EX3    = 4'd7,
        ST_HALT   = 4'd8
    } state_t;

    // Control strobes driven onto the datapath
    typedef struct packed {
        logic pc_rd_en;
        logic pc_inc;
        logic load_pc;
        logic mar_load;
        logic rom_rd_en;
        logic ir_load;
        logic ir_rd_en;
        logic acc_load;
        logic acc_rd_en;
        logic breg_load;
        logic alu_sub;
        logic alu_rd_en;
        logic out_load;
        logic halted;
    } ctrl_t;

endpackage

// File: rtl/cpu_ctrl_decoder.sv
// cpu_ctrl_decoder: purely combinational translation of (state, latched opcode)
// into datapath control strobes. Only the JZ execute step also looks at the
// live zero flag. Anything not explicitly decoded stays 0.
module cpu_ctrl_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  state_t          state,
    input  logic [OP_W-1:0] op,
    input  logic            zero_flag,
    output ctrl_t           ctrl
);

    // Decode fetch strobes from the state alone and execute strobes from the latched opcode
    always_comb begin
        ctrl = '0;
        case (state)
            ST_F_ADDR: begin
                ctrl.pc_rd_en = 1'b1;
                ctrl.mar_load = 1'b1;
            end
            ST_F_INC: begin
                ctrl.pc_inc = 1'b1;
            end
            ST_F_IR: begin
                ctrl.rom_rd_en = 1'b1;
                ctrl.ir_load   = 1'b1;
            end
            ST_EX1: begin
                case (op)
                    OP_W'(OP_LDA), OP_W'(OP_ADD), OP_W'(OP_SUB): begin
                        ctrl.ir_rd_en = 1'b1;
                        ctrl.mar_load = 1'b1;
                    end
                    OP_W'(OP_OUT): begin
                        ctrl.acc_rd_en = 1'b1;
                        ctrl.out_load  = 1'b1;
                    end
                    OP_W'(OP_JMP): begin
                        ctrl.ir_rd_en = 1'b1;
                        ctrl.load_pc  = 1'b1;
                    end
                    OP_W'(OP_JZ): begin
                        ctrl.ir_rd_en = zero_flag;
                        ctrl.load_pc  = zero_flag;
                    end
                    default: ;
                endcase
            end
            ST_EX2: begin
                case (op)
                    OP_W'(OP_LDA): begin
                        ctrl.rom_rd_en = 1'b1;
                        ctrl.acc_load  = 1'b1;
                    end
                    OP_W'(OP_ADD), OP_W'(OP_SUB): begin
                        ctrl.rom_rd_en = 1'b1;
                        ctrl.breg_load = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_EX3: begin
                case (op)
                    OP_W'(OP_ADD): begin
                        ctrl.alu_rd_en = 1'b1;
                        ctrl.acc_load  = 1'b1;
                    end
                    OP_W'(OP_SUB): begin
                        ctrl.alu_rd_en = 1'b1;
                        ctrl.acc_load  = 1'b1;
                        ctrl.alu_sub   = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_HALT: begin
                ctrl.halted = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute control FSM for a simple accumulator CPU.
// Owns the state register, the latched opcode and the retired-instruction
// counter; strobe decoding is delegated to cpu_ctrl_decoder.
// Optional build macro SINGLE_STEP_EN adds a 'step' input that gates every
// state and counter update, for single-stepping the machine by hand.
module cpu_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_W  = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_p,
    input  logic             run,
`ifdef SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic [OP_W-1:0]  opcode,
    input  logic             zero_flag,
    output logic             pc_rd_en,
    output logic             pc_inc,
    output logic             load_pc,
    output logic             mar_load,
    output logic             rom_rd_en,
    output logic             ir_load,
    output logic             ir_rd_en,
    output logic             acc_load,
    output logic             acc_rd_en,
    output logic             breg_load,
    output logic             alu_sub,
    output logic             alu_rd_en,
    output logic             out_load,
    output logic             halted,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t           state;
    state_t           state_nxt;
    logic [OP_W-1:0]  op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             advance;
    logic             is_hlt;
    logic             retire;
    ctrl_t            ctrl;

`ifdef SINGLE_STEP_EN
    assign advance = step;
`else
    assign advance = 1'b1;
`endif

    // HLT is recognised straight off the opcode bus while in DECODE
    assign is_hlt = (opcode == OP_W'(OP_HLT));

    // An instruction retires when it wraps back to fetch or when HLT parks the machine
    assign retire = advance &&
                    ((state == ST_EX3) || ((state == ST_DECODE) && is_hlt));

    // Next-state selection; the fixed seven-step walk only branches at IDLE and DECODE
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   state_nxt = run ? ST_F_ADDR : ST_IDLE;
            ST_F_ADDR: state_nxt = ST_F_INC;
            ST_F_INC:  state_nxt = ST_F_IR;
            ST_F_IR:   state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = is_hlt ? ST_HALT : ST_EX1;
            ST_EX1:    state_nxt = ST_EX2;
            ST_EX2:    state_nxt = ST_EX3;
            ST_EX3:    state_nxt = ST_F_ADDR;
            ST_HALT:   state_nxt = ST_HALT;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // State, latched opcode and retire counter; reset wins over everything, then the step gate
    always_ff @(posedge clk) begin
        if (reset_p) begin
            state <= ST_IDLE;
            op_q  <= '0;
            cnt_q <= '0;
        end else if (advance) begin
            state <= state_nxt;
            if (state == ST_DECODE) begin
                op_q <= opcode;
            end
            if (retire) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    cpu_ctrl_decoder #(
        .OP_W (OP_W)
    ) u_decoder (
        .state     (state),
        .op        (op_q),
        .zero_flag (zero_flag),
        .ctrl      (ctrl)
    );

    assign pc_rd_en  = ctrl.pc_rd_en;
    assign pc_inc    = ctrl.pc_inc;
    assign load_pc   = ctrl.load_pc;
    assign mar_load  = ctrl.mar_load;
    assign rom_rd_en = ctrl.rom_rd_en;
    assign ir_load   = ctrl.ir_load;
    assign ir_rd_en  = ctrl.ir_rd_en;
    assign acc_load  = ctrl.acc_load;
    assign acc_rd_en = ctrl.acc_rd_en;
    assign breg_load = ctrl.breg_load;
    assign alu_sub   = ctrl.alu_sub;
    assign alu_rd_en = ctrl.alu_rd_en;
    assign out_load  = ctrl.out_load;
    assign halted    = ctrl.halted;
    assign instr_cnt = cnt_q;

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 The block SHALL expose these parameters:
- OP_W, 4, opcode width.
- CNT_W, 16, retired-instruction counter width.

REQ-002 The block SHALL expose these ports:
- clk  in  1  single clock, all state on rising edge
- reset_p  in  1  synchronous, active-high reset
- run  in  1  start pulse; leaves IDLE
- opcode  in  OP_W  instruction-register opcode field
- zero_flag  in  1  accumulator-zero flag from ALU
- pc_rd_en  out  1  program counter drives bus
- pc_inc  out  1  program counter increment
- load_pc  out  1  program counter loads bus value
- mar_load  out  1  memory address register load
- rom_rd_en  out  1  program memory drives bus
- ir_load  out  1  instruction register load
- ir_rd_en  out  1  instruction register operand drives bus
- acc_load  out  1  accumulator load
- acc_rd_en  out  1  accumulator drives bus
- breg_load  out  1  B register load
- alu_sub  out  1  ALU subtract select
- alu_rd_en  out  1  ALU result drives bus
- out_load  out  1  output register load
- halted  out  1  high in HALT
- instr_cnt  out  CNT_W  retired instruction count

Function
REQ-003 The FSM SHALL have states IDLE, F_ADDR, F_INC, F_IR, DECODE, EX1, EX2, EX3, HALT, with one transition per enabled cycle.
REQ-004 All control outputs SHALL be Moore, decoded from the current state plus the latched opcode, and SHALL be 0 in any state/opcode pair not listed below.
REQ-005 State transitions:
- IDLE→F_ADDR when run=1; otherwise stay in IDLE.
- F_ADDR→F_INC→F_IR→DECODE.
- DECODE→EX1.
- EX1→EX2→EX3.
- EX3→F_ADDR.
REQ-006 Fetch control per state:
- F_ADDR: pc_rd_en=1, mar_load=1.
- F_INC: pc_inc=1.
- F_IR: rom_rd_en=1, ir_load=1.
REQ-007 DECODE SHALL latch opcode into an internal register, and all EX states SHALL use the latched value.
REQ-008 Opcodes and their EX1/EX2/EX3 controls:
- NOP=0: none / none / none.
- LDA=1: ir_rd_en+mar_load / rom_rd_en+acc_load / none.
- ADD=2: ir_rd_en+mar_load / rom_rd_en+breg_load / alu_rd_en+acc_load.
- SUB=3: same as ADD with alu_sub=1 in EX3.
- OUT=4: acc_rd_en+out_load / none / none.
- JMP=5: ir_rd_en+load_pc / none / none.
- JZ=6: ir_rd_en+load_pc only when zero_flag=1 in EX1, else nothing.
- HLT=15.
REQ-009 Opcodes 7–14 SHALL execute as NOP.
REQ-010 HLT SHALL go DECODE→HALT, and HALT SHALL be held until reset_p; run SHALL be ignored in HALT.
REQ-011 instr_cnt SHALL increment by 1 on each EX3→F_ADDR transition and on each DECODE→HALT transition, wrapping from all-ones to 0.
REQ-012 Each instruction SHALL take exactly 7 enabled cycles from F_ADDR to the next F_ADDR.
REQ-013 pc_inc and load_pc SHALL never be high in the same cycle.
REQ-014 At most one bus driver (pc_rd_en, rom_rd_en, ir_rd_en, acc_rd_en, alu_rd_en) SHALL be high in any cycle.

Reset
REQ-015 When reset_p=1 at a clock edge, the block SHALL enter IDLE, clear the latched opcode and instr_cnt, and drive all outputs to 0, regardless of current state including mid-instruction and HALT.
REQ-016 reset_p SHALL take priority over run and over the step input.

Configuration
REQ-017 With SINGLE_STEP_EN defined, the block SHALL add input port step (1 bit, after run), and state and counter SHALL advance only in cycles where step=1; otherwise they hold and outputs stay constant.
REQ-018 Without SINGLE_STEP_EN, no step port SHALL exist and the FSM SHALL advance every cycle.

Structure
REQ-019 Package cpu_ctrl_pkg SHALL hold the state enum, the opcode constants (NOP..HLT), and the instruction length constant 7.
REQ-020 Opcode-to-control decode SHALL live in one combinational sub-module, cpu_ctrl_decoder, with the state register and counter kept in cpu_sequencer.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset, then run pulse with opcode=0: F_ADDR has pc_rd_en=1+mar_load=1, next cycle pc_inc=1, next cycle ir_load=1; instr_cnt=1 after 7 cycles.
- opcode=2 (ADD): EX3 has alu_rd_en=1, acc_load=1, alu_sub=0; opcode=3 gives the same with alu_sub=1.
- opcode=6 with zero_flag=0: no load_pc in EX1; with zero_flag=1: load_pc=1, ir_rd_en=1.
- opcode=15: halted=1 from the cycle after DECODE, instr_cnt increments once, run pulses ignored; reset_p=1 returns IDLE with instr_cnt=0.
- reset_p asserted in EX2 of LDA: next cycle IDLE, all outputs 0.
- SINGLE_STEP_EN with step held 0 for 5 cycles: state and outputs frozen; then 7 step pulses complete one NOP.
